// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - programmable UART sample/baud tick and clock generator
module uart_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 54
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div_in,
    input  logic             i_div_load,
    output logic             o_div_ack,
    output logic             o_tick_sample,
    output logic             o_tick_baud,
    output logic             o_clk_baud_sample,
    output logic             o_clk_baud
);

    localparam int                BCNT_W    = $clog2(OVERSAMPLE);
    localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_HALF = BCNT_W'(OVERSAMPLE / 2);
    localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(2);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0]  r_div_act;
    logic [DIV_W-1:0]  r_pend_val;
    logic              r_pend;
    logic              r_div_ack;
    logic [DIV_W-1:0]  r_scnt;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_clk_sample;
    logic              r_clk_baud;

    logic              w_tick;
    logic              w_apply;
    logic [DIV_W-1:0]  w_div_clamped;
    logic [DIV_W-1:0]  w_div_next;
    logic [DIV_W-1:0]  w_scnt_next;
    logic [BCNT_W-1:0] w_bcnt_next;

    // Next-state for counters and divisor; the square-wave registers are fed from
    // next-state values so they line up with the counters in the same cycle.
    always_comb begin
        w_tick        = i_en && (r_scnt == (r_div_act - DIV_W'(1)));
        w_apply       = r_pend && (!i_en || w_tick);
        w_div_clamped = (i_div_in < DIV_MIN) ? DIV_MIN : i_div_in;
        w_div_next    = w_apply ? r_pend_val : r_div_act;
        w_scnt_next   = r_scnt;
        w_bcnt_next   = r_bcnt;
        if (!i_en) begin
            w_scnt_next = '0;
            w_bcnt_next = '0;
        end else if (w_tick) begin
            w_scnt_next = '0;
            w_bcnt_next = (r_bcnt == BCNT_MAX) ? '0 : r_bcnt + BCNT_W'(1);
        end else begin
            w_scnt_next = r_scnt + DIV_W'(1);
        end
    end

    // State registers; a new divisor only lands when the sample counter restarts,
    // so scnt can never sit above a freshly shrunk div_act.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_act    <= DIV_RST;
            r_pend_val   <= DIV_RST;
            r_pend       <= 1'b0;
            r_div_ack    <= 1'b0;
            r_scnt       <= '0;
            r_bcnt       <= '0;
            r_clk_sample <= 1'b1;
            r_clk_baud   <= 1'b1;
        end else begin
            r_div_act    <= w_div_next;
            r_div_ack    <= w_apply;
            r_scnt       <= w_scnt_next;
            r_bcnt       <= w_bcnt_next;
            r_clk_sample <= (w_scnt_next < (w_div_next >> 1));
            r_clk_baud   <= (w_bcnt_next < BCNT_HALF);
            if (i_div_load) begin
                r_pend_val <= w_div_clamped;
                r_pend     <= 1'b1;
            end else if (w_apply) begin
                r_pend     <= 1'b0;
            end
        end
    end

    assign o_div_ack         = r_div_ack;
    assign o_tick_sample     = w_tick;
    assign o_tick_baud       = w_tick && (r_bcnt == BCNT_MAX);
    assign o_clk_baud_sample = r_clk_sample;
    assign o_clk_baud        = r_clk_baud;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - directed self-checking bench for uart_baud_gen
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div_in;
    logic        div_load;
    logic        div_ack;
    logic        tick_sample;
    logic        tick_baud;
    logic        clk_baud_sample;
    logic        clk_baud;

    int n_err = 0;
    int n_chk = 0;
    int ack_total = 0;
    int cyc;
    int hi_len;
    int lo_len;
    int a0;

    uart_baud_gen #(.DIV_W(16), .OVERSAMPLE(16), .DEFAULT_DIV(54)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_en              (en),
        .i_div_in          (div_in),
        .i_div_load        (div_load),
        .o_div_ack         (div_ack),
        .o_tick_sample     (tick_sample),
        .o_tick_baud       (tick_baud),
        .o_clk_baud_sample (clk_baud_sample),
        .o_clk_baud        (clk_baud)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (div_ack === 1'b1) ack_total++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // negedges until tick_sample is seen (bounded)
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_sample !== 1'b1 && n < limit);
    endtask

    task automatic wait_baud(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_baud !== 1'b1 && n < limit);
    endtask

    // length of the run of clk_baud_sample==lvl starting at the current negedge
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (clk_baud_sample === lvl && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; div_in = '0; div_load = 1'b0;

        // asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_tick_sample", int'(tick_sample), 0);
        chk("rst_tick_baud", int'(tick_baud), 0);
        chk("rst_clk_sample", int'(clk_baud_sample), 1);
        chk("rst_clk_baud", int'(clk_baud), 1);
        chk("rst_div_ack", int'(div_ack), 0);

        // default divisor 54, oversample 16
        repeat (3) @(negedge clk);
        rst = 1'b0; en = 1'b1;
        wait_tick(200, cyc);  chk("def_first_tick", cyc, 53);
        wait_tick(200, cyc);  chk("def_period", cyc, 54);
        @(negedge clk);
        run_len(1'b1, hi_len); chk("def_clk_hi", hi_len, 27);
        run_len(1'b0, lo_len); chk("def_clk_lo", lo_len, 27);
        wait_baud(2000, cyc);
        wait_baud(2000, cyc); chk("def_baud_period", cyc, 864);

        // load 10 at scnt=20: current period completes, then 10-cycle periods
        wait_tick(200, cyc);
        repeat (21) @(negedge clk);
        div_in = 16'd10; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        wait_tick(200, cyc);  chk("ld10_finish_old", cyc, 32);
        @(negedge clk);       chk("ld10_ack", int'(div_ack), 1);
        wait_tick(200, cyc);  chk("ld10_first", cyc, 9);
        wait_tick(200, cyc);  chk("ld10_period", cyc, 10);
        chk("ld10_ack_low", int'(div_ack), 0);

        // en=0, load 1 (clamped to 2)
        en = 1'b0; div_in = 16'd1; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        chk("dis_tick", int'(tick_sample), 0);
        chk("dis_clk_sample", int'(clk_baud_sample), 1);
        chk("dis_clk_baud", int'(clk_baud), 1);
        chk("dis_ack_wait", int'(div_ack), 0);
        @(negedge clk);       chk("dis_ack", int'(div_ack), 1);
        @(negedge clk);       chk("dis_ack_one", int'(div_ack), 0);
        en = 1'b1;
        wait_tick(20, cyc);   chk("div2_first", cyc, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("div2_clk_sample", int'(clk_baud_sample), (i % 2 == 0) ? 1 : 0);
            chk("div2_tick", int'(tick_sample), (i % 2 == 0) ? 0 : 1);
        end

        // odd divisor 7
        en = 1'b0; div_in = 16'd7; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        @(negedge clk);       chk("div7_ack", int'(div_ack), 1);
        en = 1'b1;
        wait_tick(50, cyc);   chk("div7_first", cyc, 6);
        @(negedge clk);
        run_len(1'b1, hi_len); chk("div7_clk_hi", hi_len, 3);
        run_len(1'b0, lo_len); chk("div7_clk_lo", lo_len, 4);
        wait_baud(300, cyc);
        wait_baud(300, cyc);  chk("div7_baud_period", cyc, 112);

        // two loads in one period: latest wins, single ack
        wait_tick(50, cyc);
        a0 = ack_total;
        @(negedge clk); div_in = 16'd20; div_load = 1'b1;
        @(negedge clk); div_in = 16'd30;
        @(negedge clk); div_load = 1'b0;
        wait_tick(50, cyc);   chk("dbl_finish_old", cyc, 4);
        @(negedge clk);       chk("dbl_ack", int'(div_ack), 1);
        wait_tick(100, cyc);  chk("dbl_first", cyc, 29);
        wait_tick(100, cyc);  chk("dbl_period", cyc, 30);
        chk("dbl_ack_count", ack_total - a0, 1);

        // reset mid-period with a pending divisor
        wait_tick(100, cyc);
        repeat (20) @(negedge clk);
        div_in = 16'd10; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        chk("pre_rst_clk_sample", int'(clk_baud_sample), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tick", int'(tick_sample), 0);
        chk("mid_rst_clk_sample", int'(clk_baud_sample), 1);
        chk("mid_rst_clk_baud", int'(clk_baud), 1);
        chk("mid_rst_ack", int'(div_ack), 0);
        @(negedge clk);
        rst = 1'b0;
        a0 = ack_total;
        wait_tick(200, cyc);  chk("post_rst_first", cyc, 53);
        wait_tick(200, cyc);  chk("post_rst_period", cyc, 54);
        chk("post_rst_no_ack", ack_total - a0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of divisor path.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per baud period; legal values are even numbers 2..64.
REQ-003 SHALL have parameter DEFAULT_DIV, default 54, clk cycles per sample tick after reset (100 MHz / 54 ≈ 115200 x 16).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  generator run enable.
REQ-007 div_in  input  DIV_W  requested clk cycles per sample tick.
REQ-008 div_load  input  1  one-cycle strobe capturing div_in.
REQ-009 div_ack  output  1  one-cycle pulse when a captured divisor becomes active.
REQ-010 tick_sample  output  1  one-cycle pulse per sample period.
REQ-011 tick_baud  output  1  one-cycle pulse per baud period.
REQ-012 clk_baud_sample  output  1  square wave at sample rate.
REQ-013 clk_baud  output  1  square wave at baud rate.

Function
REQ-014 Active divisor div_act SHALL define sample period; values 0 or 1 on div_in SHALL be clamped to 2 at capture.
REQ-015 Sample counter scnt SHALL count 0..div_act-1 while en=1, wrapping to 0 after div_act-1.
REQ-016 tick_sample SHALL be 1 exactly in cycles where en=1 and scnt=div_act-1.
REQ-017 Baud counter bcnt (width clog2(OVERSAMPLE)) SHALL increment on tick_sample, wrapping to 0 after OVERSAMPLE-1.
REQ-018 tick_baud SHALL be 1 exactly in cycles where tick_sample=1 and bcnt=OVERSAMPLE-1.
REQ-019 clk_baud_sample SHALL equal (scnt < div_act>>1) in the same cycle, registered so it is glitch-free; odd div_act gives low phase one cycle longer.
REQ-020 clk_baud SHALL equal (bcnt < OVERSAMPLE/2), registered, glitch-free.
REQ-021 div_load=1 SHALL capture clamped div_in into a pending register and set pending flag; a new div_load while pending SHALL overwrite (latest wins).
REQ-022 With en=1, pending divisor SHALL become active in the cycle following a tick_sample (scnt wraps to 0 with new div_act); current sample period SHALL complete unchanged.
REQ-023 With en=0, pending divisor SHALL become active on the next clk edge.
REQ-024 div_ack SHALL pulse for exactly one cycle in the cycle the new div_act first applies; pending flag SHALL clear in that cycle.
REQ-025 div_load in the same cycle as an apply event SHALL set a new pending value, not be lost; the applied value is the previous pending.
REQ-026 en=0 SHALL force scnt=0, bcnt=0, tick_sample=0, tick_baud=0, clk_baud_sample=1, clk_baud=1 on the next edge.
REQ-027 en rising SHALL start counting from scnt=0, bcnt=0; first tick_sample SHALL occur div_act cycles after en first samples 1.
REQ-028 Counter compare SHALL be exact DIV_W-bit unsigned; no counter SHALL exceed div_act-1 even if div_act shrinks (apply only at wrap guarantees this).

Reset
REQ-029 rst=1 SHALL immediately set scnt=0, bcnt=0, div_act=DEFAULT_DIV, pending=0, div_ack=0, tick_sample=0, tick_baud=0, clk_baud_sample=1, clk_baud=1.
REQ-030 rst asserted mid-period SHALL discard any pending divisor; after release, operation SHALL resume as in REQ-027.

Verification
REQ-031 Reset release, en=1, defaults -> tick_sample every 54 cycles, tick_baud every 864 cycles, clk_baud_sample high 27 / low 27.
REQ-032 div_load with div_in=10 at scnt=20 of a 54-cycle period -> current period finishes at 54, div_ack on next cycle, then tick_sample every 10 cycles.
REQ-033 en=0, div_load div_in=1 -> div_ack next cycle, div_act=2; en=1 -> tick_sample every 2 cycles, clk_baud_sample toggles every cycle.
REQ-034 div_in=7 (odd) -> clk_baud_sample high 3 cycles, low 4 cycles; tick_baud every 112 cycles.
REQ-035 Two div_load (20 then 30) within one period -> single div_ack, active divisor 30.
REQ-036 rst pulse while pending and mid-period -> outputs at reset values asynchronously, div_act=54, no div_ack after release.
